// File: rtl/fm_hop_sequencer.sv
// Channel-hopping controller for fm_generator: holds a preset table written over a valid/ready port
// and steps through channels with a programmable dwell, strobing o_update on each parameter change.
module fm_hop_sequencer #(
  parameter int INC_W   = 31,
  parameter int DEV_W   = 17,
  parameter int NUM_CH  = 8,
  parameter int IDX_W   = 3,
  parameter int DWELL_W = 24
) (
  input  logic               i_ref_clk,
  input  logic               i_resetb,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [IDX_W-1:0]   i_cfg_addr,
  input  logic [INC_W-1:0]   i_cfg_carrier,
  input  logic [INC_W-1:0]   i_cfg_mod,
  input  logic [DEV_W-1:0]   i_cfg_dev,
  input  logic               i_run,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic [IDX_W-1:0]   i_last_ch,
  output logic [INC_W-1:0]   o_carrier_inc,
  output logic [INC_W-1:0]   o_mod_inc,
  output logic [DEV_W-1:0]   o_dev,
  output logic               o_update,
  output logic               o_ce,
  output logic [IDX_W-1:0]   o_channel,
  output logic               o_busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STROBE = 2'd2,
    S_DWELL  = 2'd3
  } state_t;

  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
  localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     chan_q, chan_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [INC_W-1:0]     car_q, car_d;
  logic [INC_W-1:0]     mod_q, mod_d;
  logic [DEV_W-1:0]     dev_q, dev_d;

  logic [INC_W-1:0]     tbl_car_q [NUM_CH];
  logic [INC_W-1:0]     tbl_mod_q [NUM_CH];
  logic [DEV_W-1:0]     tbl_dev_q [NUM_CH];

  logic                 cfg_wr;

  // Writes are blocked only while LOAD reads the table, so a copy is never torn.
  assign o_cfg_ready = (state_q != S_LOAD);
  assign cfg_wr      = i_cfg_valid & o_cfg_ready;

  always_ff @(posedge i_ref_clk) begin
    if (!i_resetb) begin
      for (int i = 0; i < NUM_CH; i++) begin
        tbl_car_q[i] <= '0;
        tbl_mod_q[i] <= '0;
        tbl_dev_q[i] <= '0;
      end
    end else if (cfg_wr) begin
      tbl_car_q[i_cfg_addr] <= i_cfg_carrier;
      tbl_mod_q[i_cfg_addr] <= i_cfg_mod;
      tbl_dev_q[i_cfg_addr] <= i_cfg_dev;
    end
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    car_d   = car_q;
    mod_d   = mod_q;
    dev_d   = dev_q;
    case (state_q)
      S_IDLE: begin
        if (i_run) begin
          chan_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        car_d   = tbl_car_q[chan_q];
        mod_d   = tbl_mod_q[chan_q];
        dev_d   = tbl_dev_q[chan_q];
        state_d = S_STROBE;
      end
      S_STROBE: begin
        // A dwell of zero behaves as one cycle; the counter never underflows.
        cnt_d   = (i_dwell == '0) ? '0 : (i_dwell - DWELL_ONE);
        state_d = S_DWELL;
      end
      S_DWELL: begin
        if (!i_run) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          chan_d  = (chan_q >= i_last_ch) ? '0 : (chan_q + IDX_ONE);
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q - DWELL_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_ref_clk) begin
    if (!i_resetb) begin
      state_q <= S_IDLE;
      chan_q  <= '0;
      cnt_q   <= '0;
      car_q   <= '0;
      mod_q   <= '0;
      dev_q   <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      car_q   <= car_d;
      mod_q   <= mod_d;
      dev_q   <= dev_d;
    end
  end

  assign o_carrier_inc = car_q;
  assign o_mod_inc     = mod_q;
  assign o_dev         = dev_q;
  assign o_channel     = chan_q;
  assign o_update      = (state_q == S_STROBE);
  assign o_ce          = (state_q != S_IDLE);
  assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fm_hop_sequencer.sv
// Scoreboard bench for fm_hop_sequencer: expected hops are queued with the stimulus and
// checked by a monitor on every o_update strobe, alongside directed reset/handshake checks.
module tb_fm_hop_sequencer;

  localparam int INC_W   = 31;
  localparam int DEV_W   = 17;
  localparam int NUM_CH  = 8;
  localparam int IDX_W   = 3;
  localparam int DWELL_W = 24;

  localparam longint C0 = 200000000, M0 = 66770, D0 = 4;
  localparam longint C1 = 100000000, M1 = 33385, D1 = 8;
  localparam longint C2 = 55555,     M2 = 777,   D2 = 3;

  logic               clk = 1'b0;
  logic               resetb;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [IDX_W-1:0]   cfg_addr;
  logic [INC_W-1:0]   cfg_carrier;
  logic [INC_W-1:0]   cfg_mod;
  logic [DEV_W-1:0]   cfg_dev;
  logic               run;
  logic [DWELL_W-1:0] dwell;
  logic [IDX_W-1:0]   last_ch;
  logic [INC_W-1:0]   carrier_inc;
  logic [INC_W-1:0]   mod_inc;
  logic [DEV_W-1:0]   dev;
  logic               update;
  logic               ce;
  logic [IDX_W-1:0]   channel;
  logic               busy;

  fm_hop_sequencer #(
    .INC_W(INC_W), .DEV_W(DEV_W), .NUM_CH(NUM_CH), .IDX_W(IDX_W), .DWELL_W(DWELL_W)
  ) dut (
    .i_ref_clk     (clk),
    .i_resetb      (resetb),
    .i_cfg_valid   (cfg_valid),
    .o_cfg_ready   (cfg_ready),
    .i_cfg_addr    (cfg_addr),
    .i_cfg_carrier (cfg_carrier),
    .i_cfg_mod     (cfg_mod),
    .i_cfg_dev     (cfg_dev),
    .i_run         (run),
    .i_dwell       (dwell),
    .i_last_ch     (last_ch),
    .o_carrier_inc (carrier_inc),
    .o_mod_inc     (mod_inc),
    .o_dev         (dev),
    .o_update      (update),
    .o_ce          (ce),
    .o_channel     (channel),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     ch;
    longint car;
    longint md;
    longint dv;
    int     gap;   // expected cycles since previous strobe; 0 = first of a run, unchecked
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;
  int   upd_cnt = 0;
  int   cyc = 0;
  int   last_upd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int ch, input longint car, input longint md, input longint dv,
                      input int gap);
    exp_t e;
    e.ch = ch; e.car = car; e.md = md; e.dv = dv; e.gap = gap;
    sb.push_back(e);
  endtask

  // Monitor: every strobe must match the next queued hop.
  always @(negedge clk) begin
    exp_t e;
    if (update === 1'b1) begin
      upd_cnt++;
      if (sb.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_update: got o_update=1 at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("upd_channel", longint'(channel), longint'(e.ch));
        chk("upd_carrier", longint'(carrier_inc), e.car);
        chk("upd_mod", longint'(mod_inc), e.md);
        chk("upd_dev", longint'(dev), e.dv);
        chk("upd_ce", longint'(ce), 1);
        if (e.gap != 0) chk("upd_period", longint'(cyc - last_upd), longint'(e.gap));
      end
      last_upd = cyc;
    end
  end

  // Returns one time step after the edge that ends the n-th strobe (first DWELL cycle).
  task automatic wait_updates(input int n);
    int g = 0;
    while (upd_cnt < n && g < 300) begin
      @(posedge clk);
      g++;
    end
    if (upd_cnt < n) begin
      vecs++;
      errs++;
      $display("FAIL wait_updates: got %0d strobes, expected %0d", upd_cnt, n);
    end
    #1;
  endtask

  task automatic cfg_write(input int addr, input longint c, input longint m, input longint d);
    int   g = 0;
    logic acc = 1'b0;
    cfg_valid   = 1'b1;
    cfg_addr    = IDX_W'(addr);
    cfg_carrier = INC_W'(c);
    cfg_mod     = INC_W'(m);
    cfg_dev     = DEV_W'(d);
    do begin
      @(negedge clk);
      acc = cfg_ready;
      @(posedge clk);
      #1;
      g++;
    end while (!acc && g < 20);
    cfg_valid = 1'b0;
    if (!acc) begin
      vecs++;
      errs++;
      $display("FAIL cfg_write: got no handshake, expected accept within 20 cycles");
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_carrier"}, longint'(carrier_inc), 0);
    chk({tag, "_mod"}, longint'(mod_inc), 0);
    chk({tag, "_dev"}, longint'(dev), 0);
    chk({tag, "_update"}, longint'(update), 0);
    chk({tag, "_ce"}, longint'(ce), 0);
    chk({tag, "_channel"}, longint'(channel), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_cfg_ready"}, longint'(cfg_ready), 1);
  endtask

  task automatic stop_run();
    run = 1'b0;
    @(negedge clk);
    chk("stop_ce_same_cycle", longint'(ce), 1);
    @(negedge clk);
    chk("stop_ce", longint'(ce), 0);
    chk("stop_busy", longint'(busy), 0);
  endtask

  initial begin
    int base;
    int g;
    resetb = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_carrier = '0; cfg_mod = '0;
    cfg_dev = '0; run = 1'b0; dwell = '0; last_ch = '0;

    // Reset held for three cycles, then ten idle cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1;
    resetb = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("idle_ce", longint'(ce), 0);
    end
    chk("idle_no_update", longint'(upd_cnt), 0);

    // Two-channel hop, dwell 5: period 7, channels 0,1,0,1.
    @(posedge clk); #1;
    cfg_write(0, C0, M0, D0);
    cfg_write(1, C1, M1, D1);
    last_ch = 3'd1;
    dwell   = 24'd5;
    push(0, C0, M0, D0, 0);
    push(1, C1, M1, D1, 7);
    push(0, C0, M0, D0, 7);
    push(1, C1, M1, D1, 7);
    run = 1'b1;
    @(negedge clk);
    chk("start_idle_busy", longint'(busy), 0);
    @(negedge clk);
    chk("start_load_busy", longint'(busy), 1);
    chk("start_load_update", longint'(update), 0);
    chk("start_load_ready", longint'(cfg_ready), 0);
    @(negedge clk);
    chk("start_strobe_update", longint'(update), 1);
    wait_updates(4);
    stop_run();
    chk("stop_hold_channel", longint'(channel), 1);
    chk("stop_hold_carrier", longint'(carrier_inc), C1);
    chk("stop_hold_dev", longint'(dev), D1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;

    // Live write to ch1 while it is being driven.
    base = upd_cnt;
    push(0, C0, M0, D0, 0);
    push(1, C1, M1, D1, 7);
    push(0, C0, M0, D0, 7);
    push(1, 123, M1, D1, 7);
    run = 1'b1;
    wait_updates(base + 2);
    cfg_write(1, 123, M1, D1);
    @(negedge clk);
    chk("live_write_hold", longint'(carrier_inc), C1);
    wait_updates(base + 4);
    stop_run();
    @(posedge clk); #1;

    // Dwell zero on channel 0, with a write held across a LOAD cycle.
    base    = upd_cnt;
    dwell   = 24'd0;
    last_ch = 3'd0;
    push(0, C0, M0, D0, 0);
    push(0, C0, M0, D0, 3);
    push(0, C2, M2, D2, 3);
    push(0, C2, M2, D2, 3);
    run = 1'b1;
    wait_updates(base + 1);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_addr = 3'd0;
    cfg_carrier = INC_W'(C2); cfg_mod = INC_W'(M2); cfg_dev = DEV_W'(D2);
    @(negedge clk);
    chk("load_write_ready", longint'(cfg_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("strobe_write_ready", longint'(cfg_ready), 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    wait_updates(base + 4);
    stop_run();
    @(posedge clk); #1;

    // Reset asserted during a STROBE cycle clears outputs and table.
    base    = upd_cnt;
    dwell   = 24'd5;
    last_ch = 3'd1;
    push(0, C2, M2, D2, 0);
    run = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (update !== 1'b1 && g < 50);
    chk("pre_reset_strobe_seen", longint'(update), 1);
    resetb = 1'b0;
    run    = 1'b0;
    @(negedge clk);
    chk_reset_vals("midreset");
    @(posedge clk); #1;
    resetb = 1'b1;
    dwell  = 24'd1;
    push(0, 0, 0, 0, 0);
    push(1, 0, 0, 0, 3);
    run = 1'b1;
    wait_updates(base + 3);
    stop_run();

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", longint'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
